// File: rtl/icache_pkg.sv
// Shared constants, state encoding and geometry helpers for the instruction cache.
package icache_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        AR,
        R,
        RESP
    } state_e;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    function automatic int word_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_words, input int num_lines);
        return addr_w - index_w(num_lines) - offset_w(line_words);
    endfunction

endpackage

// File: rtl/icache_if.sv
// AXI4 read-only channel pair between the cache (master) and the interconnect (slave).
interface icache_if #(
    parameter int ADDR_W = 32
);
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [7:0]        M_AXI_ARLEN;
    logic [2:0]        M_AXI_ARSIZE;
    logic [1:0]        M_AXI_ARBURST;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;
    logic [ADDR_W-1:0] M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RLAST;

    modport master (
        output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
        output M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST
    );

    modport slave (
        input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
        input  M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST
    );
endinterface

// File: rtl/icache_line_store.sv
// Tag/data arrays with one word-write port and an asynchronous read of the addressed line,
// plus the per-line valid vector.
module icache_line_store
    import icache_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int LINE_WORDS = 4,
    parameter  int NUM_LINES  = 16,
    localparam int INDEX_W    = index_w(NUM_LINES),
    localparam int WORD_W     = word_w(LINE_WORDS),
    localparam int TAG_W      = tag_w(ADDR_W, LINE_WORDS, NUM_LINES)
) (
    input  logic              clock,
    input  logic              rst_n_sync,
    input  logic [INDEX_W-1:0] index,
    input  logic [WORD_W-1:0]  rd_word,
    output logic [ADDR_W-1:0]  rd_data,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    input  logic               data_we,
    input  logic [WORD_W-1:0]  wr_word,
    input  logic [ADDR_W-1:0]  wr_data,
    input  logic               tag_we,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               valid_we,
    input  logic               valid_val,
    input  logic               clear_all
);

    logic [ADDR_W-1:0]    data_mem [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, valid_d;

    // NOTE: storage arrays carry no reset; the valid vector alone decides whether a line is usable.
    always_ff @(posedge clock) begin
        if (data_we) data_mem[index][wr_word] <= wr_data;
        if (tag_we)  tag_mem[index]           <= wr_tag;
    end

    always_comb begin
        valid_d = valid_q;
        if (valid_we)  valid_d[index] = valid_val;
        if (clear_all) valid_d = '0;
    end

    always_ff @(posedge clock or negedge rst_n_sync) begin
        if (!rst_n_sync) valid_q <= '0;
        else             valid_q <= valid_d;
    end

    assign rd_data  = data_mem[index][rd_word];
    assign rd_tag   = tag_mem[index];
    assign rd_valid = valid_q[index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: single outstanding fetch, line refill over an AXI4 INCR burst.
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic              clock,
    input  logic              rst_n_sync,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              fence_i,
    output logic              cache_valid,
    output logic              hit,
    output logic [ADDR_W-1:0] icache_ins,
    icache_if.master          m_axi
);

    localparam int OFFSET_W = offset_w(LINE_WORDS);
    localparam int INDEX_W  = index_w(NUM_LINES);
    localparam int WORD_W   = word_w(LINE_WORDS);
    localparam int TAG_W    = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cache_valid_q, cache_valid_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] icache_ins_q, icache_ins_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              rready_q, rready_d;
    logic [WORD_W-1:0] beat_q, beat_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              fence_pend_q, fence_pend_d;

    logic [INDEX_W-1:0] addr_index;
    logic [WORD_W-1:0]  addr_word;
    logic [TAG_W-1:0]   addr_tag;
    logic [ADDR_W-1:0]  rd_data;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic               data_we, tag_we, valid_we, valid_val, clear_all;
    logic               beat_fire, beat_err;
    logic               unused_addr_bits;

    assign addr_index       = addr_q[OFFSET_W +: INDEX_W];
    assign addr_word        = addr_q[2 +: WORD_W];
    assign addr_tag         = addr_q[ADDR_W-1 -: TAG_W];
    assign unused_addr_bits = ^addr_q[1:0];

    icache_line_store #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_store (
        .clock      (clock),
        .rst_n_sync (rst_n_sync),
        .index      (addr_index),
        .rd_word    (addr_word),
        .rd_data    (rd_data),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid),
        .data_we    (data_we),
        .wr_word    (beat_q),
        .wr_data    (m_axi.M_AXI_RDATA),
        .tag_we     (tag_we),
        .wr_tag     (addr_tag),
        .valid_we   (valid_we),
        .valid_val  (valid_val),
        .clear_all  (clear_all)
    );

    assign beat_fire = rready_q && m_axi.M_AXI_RVALID;
    assign beat_err  = beat_fire && (m_axi.M_AXI_RRESP != RESP_OKAY);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cache_valid_d = 1'b0;
        hit_d         = 1'b0;
        icache_ins_d  = icache_ins_q;
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        rready_d      = rready_q;
        beat_d        = beat_q;
        full_d        = full_q;
        err_d         = err_q;
        fence_pend_d  = fence_pend_q;
        data_we       = 1'b0;
        tag_we        = 1'b0;
        valid_we      = 1'b0;
        valid_val     = 1'b0;
        clear_all     = 1'b0;

        case (state_q)
            IDLE: begin
                clear_all = fence_i;
                if (req) begin
                    addr_d  = req_addr;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (rd_valid && rd_tag == addr_tag) begin
                    cache_valid_d = 1'b1;
                    hit_d         = 1'b1;
                    icache_ins_d  = rd_data;
                    clear_all     = fence_pend_q || fence_i;
                    state_d       = IDLE;
                end else begin
                    arvalid_d = 1'b1;
                    araddr_d  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    state_d   = AR;
                end
            end
            AR: begin
                if (m_axi.M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    beat_d    = '0;
                    full_d    = 1'b0;
                    state_d   = R;
                end
            end
            R: begin
                if (beat_fire) begin
                    data_we = !full_q;
                    if (!full_q) begin
                        if (beat_q == LAST_WORD) full_d = 1'b1;
                        else                     beat_d = beat_q + 1'b1;
                    end
                    if (beat_err) err_d = 1'b1;
                    if (m_axi.M_AXI_RLAST) begin
                        rready_d      = 1'b0;
                        tag_we        = 1'b1;
                        valid_we      = 1'b1;
                        valid_val     = !(err_q || beat_err);
                        cache_valid_d = 1'b1;
                        // The requested word may be the beat landing in the array on this edge.
                        icache_ins_d  = (data_we && beat_q == addr_word) ? m_axi.M_AXI_RDATA : rd_data;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                err_d     = 1'b0;
                clear_all = fence_pend_q || fence_i;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clear_all)    fence_pend_d = 1'b0;
        else if (fence_i) fence_pend_d = 1'b1;
    end

    // NOTE: sequential state updates use non-blocking assignments only.
    always_ff @(posedge clock or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            cache_valid_q <= 1'b0;
            hit_q         <= 1'b0;
            icache_ins_q  <= '0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            rready_q      <= 1'b0;
            beat_q        <= '0;
            full_q        <= 1'b0;
            err_q         <= 1'b0;
            fence_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cache_valid_q <= cache_valid_d;
            hit_q         <= hit_d;
            icache_ins_q  <= icache_ins_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            rready_q      <= rready_d;
            beat_q        <= beat_d;
            full_q        <= full_d;
            err_q         <= err_d;
            fence_pend_q  <= fence_pend_d;
        end
    end

    assign cache_valid         = cache_valid_q;
    assign hit                 = hit_q;
    assign icache_ins          = icache_ins_q;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_ARADDR  = araddr_q;
    assign m_axi.M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
    assign m_axi.M_AXI_ARSIZE  = SIZE_4B;
    assign m_axi.M_AXI_ARBURST = BURST_INCR;
    assign m_axi.M_AXI_RREADY  = rready_q;

endmodule
